// File: rtl/snake_game_ctrl.sv
// Snake game controller: game-tick generation, per-player direction capture with
// reversal rejection, saturating scores and the IDLE/INIT/RUN/END game flow.
module snake_game_ctrl #(
    parameter int N_PLAYERS  = 1,
    parameter int TICK_DIV   = 500000,
    parameter int SCORE_W    = 8,
    parameter int RST_CYCLES = 4,
    parameter int DIR_INIT   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4*N_PLAYERS-1:0]       key_n,
    input  logic                         start_req,
    input  logic                         pause,
    input  logic                         engine_done,
    input  logic [N_PLAYERS-1:0]         engine_grow,
    output logic                         tick,
    output logic                         engine_rst,
    output logic                         engine_start,
    output logic [2*N_PLAYERS-1:0]       dir,
    output logic [SCORE_W*N_PLAYERS-1:0] score,
    output logic [1:0]                   state,
    output logic                         game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_INIT = 2'b01,
        S_RUN  = 2'b10,
        S_END  = 2'b11
    } state_e;

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int INIT_W = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(RST_CYCLES - 1);
    localparam logic [1:0]         DIR_RST   = 2'(DIR_INIT);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_e              state_q, state_d;
    logic                rst_meta_q, rst_hold_q;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic                engine_start_q, engine_start_d;
    logic [1:0]          dir_q   [N_PLAYERS];
    logic [1:0]          dir_d   [N_PLAYERS];
    logic [1:0]          pend_q  [N_PLAYERS];
    logic [1:0]          pend_d  [N_PLAYERS];
    logic [SCORE_W-1:0]  score_q [N_PLAYERS];
    logic [SCORE_W-1:0]  score_d [N_PLAYERS];
    logic [2:0]          req;

    // {valid, direction}; direction codes double as priority (up > left > right > down)
    function automatic logic [2:0] key_req(input logic [3:0] kn);
        if (!kn[0])      return {1'b1, 2'd0};
        else if (!kn[2]) return {1'b1, 2'd1};
        else if (!kn[1]) return {1'b1, 2'd2};
        else if (!kn[3]) return {1'b1, 2'd3};
        else             return 3'b000;
    endfunction

    // Reset asserts asynchronously; the hold flag keeps the FSM in IDLE for two edges after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_hold_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_hold_q <= rst_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_req && !rst_hold_q) state_d = S_INIT;
            S_INIT:  if (init_cnt_q == INIT_LAST) state_d = S_RUN;
            S_RUN:   if (engine_done) state_d = S_END;
            S_END:   if (start_req) state_d = S_INIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tick         = 1'b0;
        engine_rst   = 1'b0;
        game_over    = 1'b0;
        engine_start = engine_start_q;
        state        = state_q;
        case (state_q)
            S_IDLE, S_INIT: engine_rst = 1'b1;
            S_RUN:          tick = !pause && (tick_cnt_q == TICK_LAST);
            S_END:          game_over = 1'b1;
            default:        engine_rst = 1'b1;
        endcase
    end

    always_comb begin
        tick_cnt_d     = '0;
        init_cnt_d     = '0;
        engine_start_d = (state_q == S_INIT) && (state_d == S_RUN);
        if (state_q == S_RUN && state_d == S_RUN) begin
            if (pause)     tick_cnt_d = tick_cnt_q;
            else if (tick) tick_cnt_d = '0;
            else           tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
        if (state_q == S_INIT && state_d == S_INIT) begin
            init_cnt_d = init_cnt_q + INIT_W'(1);
        end
    end

    // A tick commits pending and drops that cycle's request, so one turn per tick at most
    always_comb begin
        req = 3'b000;
        for (int p = 0; p < N_PLAYERS; p++) begin
            dir_d[p]   = dir_q[p];
            pend_d[p]  = pend_q[p];
            score_d[p] = score_q[p];
            req        = key_req(key_n[4*p +: 4]);
            if (state_d == S_INIT) begin
                dir_d[p]   = DIR_RST;
                pend_d[p]  = DIR_RST;
                score_d[p] = '0;
            end else if (state_q == S_RUN) begin
                if (engine_grow[p] && score_q[p] != SCORE_MAX) begin
                    score_d[p] = score_q[p] + SCORE_W'(1);
                end
                if (tick) begin
                    dir_d[p] = pend_q[p];
                end else if (!pause && req[2] && req[1:0] != ~dir_q[p]) begin
                    pend_d[p] = req[1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q     <= '0;
            init_cnt_q     <= '0;
            engine_start_q <= 1'b0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                dir_q[p]   <= DIR_RST;
                pend_q[p]  <= DIR_RST;
                score_q[p] <= '0;
            end
        end else begin
            tick_cnt_q     <= tick_cnt_d;
            init_cnt_q     <= init_cnt_d;
            engine_start_q <= engine_start_d;
            for (int p = 0; p < N_PLAYERS; p++) begin
                dir_q[p]   <= dir_d[p];
                pend_q[p]  <= pend_d[p];
                score_q[p] <= score_d[p];
            end
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
        assign dir[2*g +: 2]             = dir_q[g];
        assign score[SCORE_W*g +: SCORE_W] = score_q[g];
    end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 1, meaning number of snakes/key groups (1..4).
REQ-002 SHALL have parameter TICK_DIV, default 500000, meaning clk cycles per game tick (>=2).
REQ-003 SHALL have parameter SCORE_W, default 8, meaning per-player score width.
REQ-004 SHALL have parameter RST_CYCLES, default 4, meaning engine reset pulse length in cycles (>=1).
REQ-005 SHALL have parameter DIR_INIT, default 2, meaning initial direction (0 up, 1 left, 2 right, 3 down).
REQ-006 SHALL have ports in this order:
- clk  input  1  sole clock
- rst  input  1  reset, asynchronous, active-high
- key_n  input  4*N_PLAYERS  active-low keys per player p at [4p+3:4p]: bit0 up, bit1 right, bit2 left, bit3 down
- start_req  input  1  start/restart request, level
- pause  input  1  freeze game while high
- engine_done  input  1  display engine reports game over
- engine_grow  input  N_PLAYERS  per-player food-eaten pulse
- tick  output  1  single-cycle game step enable
- engine_rst  output  1  active-high reset to display engine
- engine_start  output  1  single-cycle start pulse
- dir  output  2*N_PLAYERS  committed direction of player p at [2p+1:2p]
- score  output  SCORE_W*N_PLAYERS  score of player p at [SCORE_W*p +: SCORE_W]
- state  output  2  00 IDLE, 01 INIT, 10 RUN, 11 END
- game_over  output  1  high in END

Function
REQ-007 SHALL use a single-cycle enable for the tick, never a derived clock; all logic SHALL be clocked on clk.
REQ-008 Tick counter SHALL count 0..TICK_DIV-1 only in RUN with pause low; tick SHALL be 1 in the cycle the counter equals TICK_DIV-1, and the counter SHALL then wrap to 0.
REQ-009 Counter SHALL hold its value while pause is high in RUN and SHALL be 0 in every other state.
REQ-010 IDLE: start_req high SHALL move to INIT next cycle.
REQ-011 INIT: engine_rst SHALL be 1 for exactly RST_CYCLES cycles; all dir SHALL be DIR_INIT and all scores 0; then RUN.
REQ-012 engine_start SHALL pulse 1 in the first RUN cycle only.
REQ-013 RUN, per player, each cycle: the requested direction SHALL be the lowest-numbered pressed key by priority up > left > right > down; no key pressed SHALL mean no request.
REQ-014 A request SHALL be latched into a per-player pending register only if it is not the opposite (3 - dir) of the committed dir; reversal SHALL be checked against committed dir, not pending.
REQ-015 On tick, committed dir SHALL take pending; pending SHALL then equal committed; at most one direction change per player per tick.
REQ-016 Pending SHALL not update and committed dir SHALL not change while pause is high.
REQ-017 engine_grow[p] high in a RUN cycle SHALL increment score[p] by 1, saturating at 2^SCORE_W-1; grow is counted regardless of pause.
REQ-018 engine_done high in RUN SHALL move to END next cycle; a grow in the same cycle SHALL still be counted.
REQ-019 END: game_over SHALL be 1, scores and dir SHALL hold; start_req SHALL move to INIT, and game_over SHALL clear on leaving END.
REQ-020 start_req SHALL be ignored in INIT and RUN; pause, keys and engine_grow SHALL be ignored outside RUN; engine_done SHALL be ignored outside RUN.

Reset
REQ-021 rst high SHALL immediately force state IDLE, tick 0, engine_rst 1, engine_start 0, game_over 0, scores 0, dir DIR_INIT, pending DIR_INIT, counter 0.
REQ-022 engine_rst SHALL be 1 in IDLE and INIT and 0 in RUN and END; reset mid-game SHALL abandon the game with no END visit.
REQ-023 Reset release SHALL be synchronised so the first state change occurs no earlier than the second clk edge after deassertion.

Verification (N_PLAYERS=2, TICK_DIV=4, SCORE_W=4, RST_CYCLES=2, DIR_INIT=2)
REQ-024 Start: start_req pulse in IDLE -> INIT with engine_rst high 2 cycles, RUN, engine_start one cycle, tick every 4th cycle.
REQ-025 Reversal: player 0 dir=2, press left (key_n[2]=0) -> dir stays 2 after tick; press up -> dir=0 after next tick.
REQ-026 Double press in one tick: dir=2, press up then left before tick -> pending up accepted, left rejected as not opposite of committed? no: left is opposite of committed right -> dir=0 after tick.
REQ-027 Pause: pause high 10 cycles mid-count at counter=2 -> no tick, dir frozen; resume -> tick 2 cycles later.
REQ-028 Score: 17 grow pulses to player 1 -> score[1]=15; engine_done with simultaneous grow on player 0 -> END, score[0] incremented, game_over=1.
REQ-029 Reset mid-RUN: rst pulse -> state 00, scores 0, dir both 2, engine_rst 1.
